// File: rtl/fpga_top.sv
// fpga_top: FPGA shell around the host.
//   ctrl   : AXI4 slave (32b data) onto a 16-entry MMIO register file.
//   mem_0  : AXI4 master (64b data), single-beat DMA driven by MEM_CMD.
//   qsfp_0 : one-word TX/RX mailbox driven by QSFP_CMD.
// Ports:
//   clock, reset (async, active-low)
//   ctrl_{ar,aw,w,r,b}_*   AXI4 slave channels
//   mem_0_{ar,aw,w,r,b}_*  AXI4 master channels
//   qsfp_0_channel_up, qsfp_0_tx_*, qsfp_0_rx_*
module fpga_top #(
  parameter int CTRL_ADDR_BITS = 12,
  parameter int CTRL_ID_BITS   = 12,
  parameter int MEM_ADDR_BITS  = 34,
  parameter int MEM_ID_BITS    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  // ctrl AR
  input  logic                      ctrl_ar_valid,
  output logic                      ctrl_ar_ready,
  input  logic [CTRL_ADDR_BITS-1:0] ctrl_ar_bits_addr,
  input  logic [CTRL_ID_BITS-1:0]   ctrl_ar_bits_id,
  input  logic [2:0]                ctrl_ar_bits_size,
  input  logic [7:0]                ctrl_ar_bits_len,
  // ctrl AW
  input  logic                      ctrl_aw_valid,
  output logic                      ctrl_aw_ready,
  input  logic [CTRL_ADDR_BITS-1:0] ctrl_aw_bits_addr,
  input  logic [CTRL_ID_BITS-1:0]   ctrl_aw_bits_id,
  input  logic [2:0]                ctrl_aw_bits_size,
  input  logic [7:0]                ctrl_aw_bits_len,
  // ctrl W
  input  logic                      ctrl_w_valid,
  output logic                      ctrl_w_ready,
  input  logic [3:0]                ctrl_w_bits_strb,
  input  logic [31:0]               ctrl_w_bits_data,
  input  logic                      ctrl_w_bits_last,
  // ctrl R
  output logic                      ctrl_r_valid,
  input  logic                      ctrl_r_ready,
  output logic [1:0]                ctrl_r_bits_resp,
  output logic [CTRL_ID_BITS-1:0]   ctrl_r_bits_id,
  output logic [31:0]               ctrl_r_bits_data,
  output logic                      ctrl_r_bits_last,
  // ctrl B
  output logic                      ctrl_b_valid,
  input  logic                      ctrl_b_ready,
  output logic [1:0]                ctrl_b_bits_resp,
  output logic [CTRL_ID_BITS-1:0]   ctrl_b_bits_id,
  // mem_0 AR
  output logic                      mem_0_ar_valid,
  input  logic                      mem_0_ar_ready,
  output logic [MEM_ADDR_BITS-1:0]  mem_0_ar_bits_addr,
  output logic [MEM_ID_BITS-1:0]    mem_0_ar_bits_id,
  output logic [2:0]                mem_0_ar_bits_size,
  output logic [7:0]                mem_0_ar_bits_len,
  // mem_0 AW
  output logic                      mem_0_aw_valid,
  input  logic                      mem_0_aw_ready,
  output logic [MEM_ADDR_BITS-1:0]  mem_0_aw_bits_addr,
  output logic [MEM_ID_BITS-1:0]    mem_0_aw_bits_id,
  output logic [2:0]                mem_0_aw_bits_size,
  output logic [7:0]                mem_0_aw_bits_len,
  // mem_0 W
  output logic                      mem_0_w_valid,
  input  logic                      mem_0_w_ready,
  output logic [7:0]                mem_0_w_bits_strb,
  output logic [63:0]               mem_0_w_bits_data,
  output logic                      mem_0_w_bits_last,
  // mem_0 R
  input  logic                      mem_0_r_valid,
  output logic                      mem_0_r_ready,
  input  logic [1:0]                mem_0_r_bits_resp,
  input  logic [MEM_ID_BITS-1:0]    mem_0_r_bits_id,
  input  logic [63:0]               mem_0_r_bits_data,
  input  logic                      mem_0_r_bits_last,
  // mem_0 B
  input  logic                      mem_0_b_valid,
  output logic                      mem_0_b_ready,
  input  logic [1:0]                mem_0_b_bits_resp,
  input  logic [MEM_ID_BITS-1:0]    mem_0_b_bits_id,
  // QSFP
  input  logic                      qsfp_0_channel_up,
  output logic                      qsfp_0_tx_valid,
  input  logic                      qsfp_0_tx_ready,
  output logic [63:0]               qsfp_0_tx_bits,
  input  logic                      qsfp_0_rx_valid,
  output logic                      qsfp_0_rx_ready,
  input  logic [63:0]               qsfp_0_rx_bits
);

  localparam logic [31:0] ID_VALUE = 32'h4650_4741;

  localparam logic [3:0] R_ID       = 4'h0, R_SCRATCH  = 4'h1, R_ADDR_LO = 4'h2,
                         R_ADDR_HI  = 4'h3, R_WDATA_LO = 4'h4, R_WDATA_HI = 4'h5,
                         R_RDATA_LO = 4'h6, R_RDATA_HI = 4'h7, R_MEM_CMD = 4'h8,
                         R_STATUS   = 4'h9, R_TX_LO    = 4'hA, R_TX_HI    = 4'hB,
                         R_QSFP_CMD = 4'hC, R_RX_LO    = 4'hD, R_RX_HI    = 4'hE,
                         R_UNMAPPED = 4'hF;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} dma_state_t;

  // Any address bit above [5:2] set, or offset 0x3C, lands on the unmapped slot.
  function automatic logic [3:0] reg_idx(input logic [CTRL_ADDR_BITS-1:0] a);
    logic [3:0] idx;
    idx = a[5:2];
    if ((a >> 6) != '0) idx = R_UNMAPPED;
    return idx;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  // Held low through the first cycle after reset so every ready output is 0 in reset.
  logic alive;

  // registers
  logic [31:0] scratch, addr_lo, addr_hi, wdata_lo, wdata_hi, rdata_lo, rdata_hi, tx_lo, tx_hi;
  logic [63:0] rx_word, tx_word;
  logic        done, cmd_err, tx_busy, rx_full;
  logic [1:0]  mem_resp;

  // ctrl write buffers
  logic                      aw_full, w_full;
  logic [CTRL_ADDR_BITS-1:0] aw_addr_q;
  logic [CTRL_ID_BITS-1:0]   aw_id_q;
  logic [31:0]               w_data_q;
  logic [3:0]                w_strb_q;
  logic                      w_last_q;

  // ctrl read state
  logic [7:0]  r_cnt;

  // DMA
  dma_state_t state_q, state_d;
  logic       aw_pend, w_pend;
  logic [63:0] mem_addr64;

  logic        busy, wr_en, start_rd, start_wr, cmd_bad, dma_finish;
  logic [3:0]  wr_idx, rd_idx;
  logic [1:0]  wcmd;
  logic [31:0] rd_mux, status;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign busy   = (state_q != S_IDLE);
  assign status = {21'b0, qsfp_0_channel_up, rx_full, tx_busy, 3'b0, cmd_err, mem_resp, done, busy};

  // ---------------- ctrl write path ----------------
  assign ctrl_aw_ready = alive & ~aw_full & ~ctrl_b_valid;
  assign ctrl_w_ready  = alive & ~w_full;
  assign wr_en  = aw_full & w_full;
  assign wr_idx = reg_idx(aw_addr_q);
  assign wcmd   = w_data_q[1:0] & {2{w_strb_q[0]}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_full          <= 1'b0;
      w_full           <= 1'b0;
      aw_addr_q        <= '0;
      aw_id_q          <= '0;
      w_data_q         <= '0;
      w_strb_q         <= '0;
      w_last_q         <= 1'b0;
      ctrl_b_valid     <= 1'b0;
      ctrl_b_bits_resp <= 2'b00;
      ctrl_b_bits_id   <= '0;
    end else begin
      if (ctrl_aw_valid && ctrl_aw_ready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= ctrl_aw_bits_addr;
        aw_id_q   <= ctrl_aw_bits_id;
      end
      if (ctrl_w_valid && ctrl_w_ready) begin
        w_full   <= 1'b1;
        w_data_q <= ctrl_w_bits_data;
        w_strb_q <= ctrl_w_bits_strb;
        w_last_q <= ctrl_w_bits_last;
      end
      if (wr_en) begin
        w_full <= 1'b0;
        if (w_last_q) begin
          aw_full          <= 1'b0;
          ctrl_b_valid     <= 1'b1;
          ctrl_b_bits_resp <= (wr_idx == R_UNMAPPED) ? 2'b10 : 2'b00;
          ctrl_b_bits_id   <= aw_id_q;
        end
      end
      if (ctrl_b_valid && ctrl_b_ready) ctrl_b_valid <= 1'b0;
    end
  end

  // ---------------- ctrl read path ----------------
  assign ctrl_ar_ready    = alive & ~ctrl_r_valid;
  assign ctrl_r_bits_last = (r_cnt == 8'd0);
  assign rd_idx           = reg_idx(ctrl_ar_bits_addr);

  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      R_ID:       rd_mux = ID_VALUE;
      R_SCRATCH:  rd_mux = scratch;
      R_ADDR_LO:  rd_mux = addr_lo;
      R_ADDR_HI:  rd_mux = addr_hi;
      R_WDATA_LO: rd_mux = wdata_lo;
      R_WDATA_HI: rd_mux = wdata_hi;
      R_RDATA_LO: rd_mux = rdata_lo;
      R_RDATA_HI: rd_mux = rdata_hi;
      R_STATUS:   rd_mux = status;
      R_TX_LO:    rd_mux = tx_lo;
      R_TX_HI:    rd_mux = tx_hi;
      R_RX_LO:    rd_mux = rx_word[31:0];
      R_RX_HI:    rd_mux = rx_word[63:32];
      default:    rd_mux = 32'h0;
    endcase
  end

  // Data is snapshotted at the AR handshake, so a same-cycle write is not visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_r_valid     <= 1'b0;
      ctrl_r_bits_data <= '0;
      ctrl_r_bits_resp <= 2'b00;
      ctrl_r_bits_id   <= '0;
      r_cnt            <= '0;
    end else if (ctrl_ar_valid && ctrl_ar_ready) begin
      ctrl_r_valid     <= 1'b1;
      ctrl_r_bits_data <= rd_mux;
      ctrl_r_bits_resp <= (rd_idx == R_UNMAPPED) ? 2'b10 : 2'b00;
      ctrl_r_bits_id   <= ctrl_ar_bits_id;
      r_cnt            <= ctrl_ar_bits_len;
    end else if (ctrl_r_valid && ctrl_r_ready) begin
      if (r_cnt == 8'd0) ctrl_r_valid <= 1'b0;
      else               r_cnt        <= r_cnt - 8'd1;
    end
  end

  // ---------------- register file / commands ----------------
  assign cmd_bad    = (wcmd != 2'b00) && (busy || wcmd == 2'b11);
  assign start_rd   = wr_en && wr_idx == R_MEM_CMD && !busy && wcmd == 2'b01;
  assign start_wr   = wr_en && wr_idx == R_MEM_CMD && !busy && wcmd == 2'b10;
  assign dma_finish = (state_q == S_R && mem_0_r_valid) || (state_q == S_B && mem_0_b_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scratch  <= '0; addr_lo  <= '0; addr_hi  <= '0;
      wdata_lo <= '0; wdata_hi <= '0; rdata_lo <= '0; rdata_hi <= '0;
      tx_lo    <= '0; tx_hi    <= '0; tx_word  <= '0; rx_word  <= '0;
      done     <= 1'b0; cmd_err <= 1'b0; mem_resp <= 2'b00;
      tx_busy  <= 1'b0; rx_full <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_idx)
          R_SCRATCH:  scratch  <= merge(scratch,  w_data_q, w_strb_q);
          R_ADDR_LO:  addr_lo  <= merge(addr_lo,  w_data_q, w_strb_q);
          R_ADDR_HI:  addr_hi  <= merge(addr_hi,  w_data_q, w_strb_q);
          R_WDATA_LO: wdata_lo <= merge(wdata_lo, w_data_q, w_strb_q);
          R_WDATA_HI: wdata_hi <= merge(wdata_hi, w_data_q, w_strb_q);
          R_TX_LO:    tx_lo    <= merge(tx_lo,    w_data_q, w_strb_q);
          R_TX_HI:    tx_hi    <= merge(tx_hi,    w_data_q, w_strb_q);
          R_MEM_CMD: begin
            done    <= 1'b0;
            cmd_err <= cmd_bad;
          end
          R_QSFP_CMD: begin
            if (wcmd[0] && !tx_busy) begin
              tx_word <= {tx_hi, tx_lo};
              tx_busy <= 1'b1;
            end
            if (wcmd[1]) rx_full <= 1'b0;
          end
          default: ;
        endcase
      end
      // A send can only be accepted while idle, so it never collides with a handshake.
      if (qsfp_0_tx_valid && qsfp_0_tx_ready) tx_busy <= 1'b0;
      if (qsfp_0_rx_valid && qsfp_0_rx_ready) begin
        rx_word <= qsfp_0_rx_bits;
        rx_full <= 1'b1;
      end
      if (state_q == S_R && mem_0_r_valid) begin
        rdata_lo <= mem_0_r_bits_data[31:0];
        rdata_hi <= mem_0_r_bits_data[63:32];
        mem_resp <= mem_0_r_bits_resp;
      end
      if (state_q == S_B && mem_0_b_valid) mem_resp <= mem_0_b_bits_resp;
      if (dma_finish) done <= 1'b1;
    end
  end

  // ---------------- QSFP ----------------
  assign qsfp_0_tx_valid = tx_busy & qsfp_0_channel_up;
  assign qsfp_0_tx_bits  = tx_word;
  assign qsfp_0_rx_ready = alive & qsfp_0_channel_up & ~rx_full;

  // ---------------- DMA FSM ----------------
  assign mem_addr64 = {addr_hi, addr_lo};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_wr) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (mem_0_aw_valid && mem_0_aw_ready) aw_pend <= 1'b0;
        if (mem_0_w_valid && mem_0_w_ready)   w_pend  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_0_ar_valid = 1'b0;
    mem_0_aw_valid = 1'b0;
    mem_0_w_valid  = 1'b0;
    mem_0_r_ready  = 1'b0;
    mem_0_b_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rd)      state_d = S_AR;
        else if (start_wr) state_d = S_AWW;
      end
      S_AR: begin
        mem_0_ar_valid = 1'b1;
        if (mem_0_ar_ready) state_d = S_R;
      end
      S_R: begin
        mem_0_r_ready = 1'b1;
        if (mem_0_r_valid) state_d = S_IDLE;
      end
      S_AWW: begin
        mem_0_aw_valid = aw_pend;
        mem_0_w_valid  = w_pend;
        // Advance once both channels have handshaken, in either order.
        if ((!aw_pend || mem_0_aw_ready) && (!w_pend || mem_0_w_ready)) state_d = S_B;
      end
      S_B: begin
        mem_0_b_ready = 1'b1;
        if (mem_0_b_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_0_ar_bits_addr = mem_addr64[MEM_ADDR_BITS-1:0];
  assign mem_0_aw_bits_addr = mem_addr64[MEM_ADDR_BITS-1:0];
  assign mem_0_ar_bits_id   = '0;
  assign mem_0_aw_bits_id   = '0;
  assign mem_0_ar_bits_size = 3'd3;
  assign mem_0_aw_bits_size = 3'd3;
  assign mem_0_ar_bits_len  = 8'd0;
  assign mem_0_aw_bits_len  = 8'd0;
  assign mem_0_w_bits_strb  = 8'hFF;
  assign mem_0_w_bits_data  = {wdata_hi, wdata_lo};
  assign mem_0_w_bits_last  = 1'b1;

  // Inputs and bits that carry no meaning for this shell.
  logic unused;
  assign unused = ^{ctrl_ar_bits_size, ctrl_aw_bits_size, ctrl_aw_bits_len,
                    ctrl_ar_bits_addr[1:0], aw_addr_q[1:0], mem_addr64,
                    mem_0_r_bits_id, mem_0_r_bits_last, mem_0_b_bits_id};

endmodule

// File: tb/tb_fpga_top.sv
module tb_fpga_top;
  logic        clock, reset;
  logic        ctrl_ar_valid, ctrl_ar_ready; logic [11:0] ctrl_ar_bits_addr, ctrl_ar_bits_id;
  logic [2:0]  ctrl_ar_bits_size; logic [7:0] ctrl_ar_bits_len;
  logic        ctrl_aw_valid, ctrl_aw_ready; logic [11:0] ctrl_aw_bits_addr, ctrl_aw_bits_id;
  logic [2:0]  ctrl_aw_bits_size; logic [7:0] ctrl_aw_bits_len;
  logic        ctrl_w_valid, ctrl_w_ready, ctrl_w_bits_last;
  logic [3:0]  ctrl_w_bits_strb; logic [31:0] ctrl_w_bits_data;
  logic        ctrl_r_valid, ctrl_r_ready, ctrl_r_bits_last; logic [1:0] ctrl_r_bits_resp;
  logic [11:0] ctrl_r_bits_id; logic [31:0] ctrl_r_bits_data;
  logic        ctrl_b_valid, ctrl_b_ready; logic [1:0] ctrl_b_bits_resp; logic [11:0] ctrl_b_bits_id;
  logic        mem_0_ar_valid, mem_0_ar_ready; logic [33:0] mem_0_ar_bits_addr;
  logic [15:0] mem_0_ar_bits_id; logic [2:0] mem_0_ar_bits_size; logic [7:0] mem_0_ar_bits_len;
  logic        mem_0_aw_valid, mem_0_aw_ready; logic [33:0] mem_0_aw_bits_addr;
  logic [15:0] mem_0_aw_bits_id; logic [2:0] mem_0_aw_bits_size; logic [7:0] mem_0_aw_bits_len;
  logic        mem_0_w_valid, mem_0_w_ready, mem_0_w_bits_last;
  logic [7:0]  mem_0_w_bits_strb; logic [63:0] mem_0_w_bits_data;
  logic        mem_0_r_valid, mem_0_r_ready, mem_0_r_bits_last; logic [1:0] mem_0_r_bits_resp;
  logic [15:0] mem_0_r_bits_id; logic [63:0] mem_0_r_bits_data;
  logic        mem_0_b_valid, mem_0_b_ready; logic [1:0] mem_0_b_bits_resp; logic [15:0] mem_0_b_bits_id;
  logic        qsfp_0_channel_up, qsfp_0_tx_valid, qsfp_0_tx_ready, qsfp_0_rx_valid, qsfp_0_rx_ready;
  logic [63:0] qsfp_0_tx_bits, qsfp_0_rx_bits;

  fpga_top dut (
    .clock(clock), .reset(reset),
    .ctrl_ar_valid(ctrl_ar_valid), .ctrl_ar_ready(ctrl_ar_ready), .ctrl_ar_bits_addr(ctrl_ar_bits_addr),
    .ctrl_ar_bits_id(ctrl_ar_bits_id), .ctrl_ar_bits_size(ctrl_ar_bits_size), .ctrl_ar_bits_len(ctrl_ar_bits_len),
    .ctrl_aw_valid(ctrl_aw_valid), .ctrl_aw_ready(ctrl_aw_ready), .ctrl_aw_bits_addr(ctrl_aw_bits_addr),
    .ctrl_aw_bits_id(ctrl_aw_bits_id), .ctrl_aw_bits_size(ctrl_aw_bits_size), .ctrl_aw_bits_len(ctrl_aw_bits_len),
    .ctrl_w_valid(ctrl_w_valid), .ctrl_w_ready(ctrl_w_ready), .ctrl_w_bits_strb(ctrl_w_bits_strb),
    .ctrl_w_bits_data(ctrl_w_bits_data), .ctrl_w_bits_last(ctrl_w_bits_last),
    .ctrl_r_valid(ctrl_r_valid), .ctrl_r_ready(ctrl_r_ready), .ctrl_r_bits_resp(ctrl_r_bits_resp),
    .ctrl_r_bits_id(ctrl_r_bits_id), .ctrl_r_bits_data(ctrl_r_bits_data), .ctrl_r_bits_last(ctrl_r_bits_last),
    .ctrl_b_valid(ctrl_b_valid), .ctrl_b_ready(ctrl_b_ready), .ctrl_b_bits_resp(ctrl_b_bits_resp),
    .ctrl_b_bits_id(ctrl_b_bits_id),
    .mem_0_ar_valid(mem_0_ar_valid), .mem_0_ar_ready(mem_0_ar_ready), .mem_0_ar_bits_addr(mem_0_ar_bits_addr),
    .mem_0_ar_bits_id(mem_0_ar_bits_id), .mem_0_ar_bits_size(mem_0_ar_bits_size), .mem_0_ar_bits_len(mem_0_ar_bits_len),
    .mem_0_aw_valid(mem_0_aw_valid), .mem_0_aw_ready(mem_0_aw_ready), .mem_0_aw_bits_addr(mem_0_aw_bits_addr),
    .mem_0_aw_bits_id(mem_0_aw_bits_id), .mem_0_aw_bits_size(mem_0_aw_bits_size), .mem_0_aw_bits_len(mem_0_aw_bits_len),
    .mem_0_w_valid(mem_0_w_valid), .mem_0_w_ready(mem_0_w_ready), .mem_0_w_bits_strb(mem_0_w_bits_strb),
    .mem_0_w_bits_data(mem_0_w_bits_data), .mem_0_w_bits_last(mem_0_w_bits_last),
    .mem_0_r_valid(mem_0_r_valid), .mem_0_r_ready(mem_0_r_ready), .mem_0_r_bits_resp(mem_0_r_bits_resp),
    .mem_0_r_bits_id(mem_0_r_bits_id), .mem_0_r_bits_data(mem_0_r_bits_data), .mem_0_r_bits_last(mem_0_r_bits_last),
    .mem_0_b_valid(mem_0_b_valid), .mem_0_b_ready(mem_0_b_ready), .mem_0_b_bits_resp(mem_0_b_bits_resp),
    .mem_0_b_bits_id(mem_0_b_bits_id),
    .qsfp_0_channel_up(qsfp_0_channel_up), .qsfp_0_tx_valid(qsfp_0_tx_valid), .qsfp_0_tx_ready(qsfp_0_tx_ready),
    .qsfp_0_tx_bits(qsfp_0_tx_bits), .qsfp_0_rx_valid(qsfp_0_rx_valid), .qsfp_0_rx_ready(qsfp_0_rx_ready),
    .qsfp_0_rx_bits(qsfp_0_rx_bits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int aw_cnt = 0, ar_cnt = 0;
  logic [31:0] rd_data [8];
  logic        rd_last [8];
  logic [1:0]  rd_resp;
  logic [11:0] rd_id;
  int          rd_n;

  always @(posedge clock) begin
    if (mem_0_aw_valid && mem_0_aw_ready) aw_cnt++;
    if (mem_0_ar_valid && mem_0_ar_ready) ar_cnt++;
  end

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  len;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [12];

  function automatic vec_t mk(input logic wr, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [7:0] l, input logic [31:0] ed,
                              input logic [1:0] er);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.len = l; v.exp_data = ed; v.exp_resp = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ctrl_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [11:0] id, output logic [1:0] resp, output logic [11:0] bid);
    int n;
    logic aw_hs, w_hs;
    resp = 2'bxx; bid = 'x;
    @(posedge clock); #1;
    ctrl_aw_valid = 1; ctrl_aw_bits_addr = a; ctrl_aw_bits_id = id;
    ctrl_w_valid = 1; ctrl_w_bits_data = d; ctrl_w_bits_strb = s; ctrl_w_bits_last = 1;
    n = 0;
    while ((ctrl_aw_valid || ctrl_w_valid) && n < 50) begin
      @(negedge clock); aw_hs = ctrl_aw_ready; w_hs = ctrl_w_ready;
      @(posedge clock); #1;
      if (aw_hs) ctrl_aw_valid = 0;
      if (w_hs) ctrl_w_valid = 0;
      n++;
    end
    if (n >= 50) check("ctrl_aw_w_timeout", 1, 0);
    ctrl_aw_valid = 0; ctrl_w_valid = 0;
    ctrl_b_ready = 1; n = 0;
    while (n < 50) begin
      @(negedge clock);
      if (ctrl_b_valid) begin resp = ctrl_b_bits_resp; bid = ctrl_b_bits_id; break; end
      n++;
    end
    if (n >= 50) check("ctrl_b_timeout", 1, 0);
    @(posedge clock); #1; ctrl_b_ready = 0;
  endtask

  task automatic ctrl_read(input logic [11:0] a, input logic [7:0] len, input logic [11:0] id);
    int n;
    logic hs;
    rd_n = 0;
    @(posedge clock); #1;
    ctrl_ar_valid = 1; ctrl_ar_bits_addr = a; ctrl_ar_bits_id = id; ctrl_ar_bits_len = len;
    n = 0;
    while (ctrl_ar_valid && n < 50) begin
      @(negedge clock); hs = ctrl_ar_ready;
      @(posedge clock); #1; if (hs) ctrl_ar_valid = 0;
      n++;
    end
    if (n >= 50) check("ctrl_ar_timeout", 1, 0);
    ctrl_ar_valid = 0;
    ctrl_r_ready = 1; n = 0;
    while (n < 50) begin
      @(negedge clock);
      if (ctrl_r_valid) begin
        rd_data[rd_n] = ctrl_r_bits_data; rd_last[rd_n] = ctrl_r_bits_last;
        rd_resp = ctrl_r_bits_resp; rd_id = ctrl_r_bits_id; rd_n++;
        if (ctrl_r_bits_last || rd_n == 8) begin @(posedge clock); #1; break; end
      end
      n++;
    end
    if (n >= 50) check("ctrl_r_timeout", 1, 0);
    ctrl_r_ready = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [1:0] r; logic [11:0] b;
    ctrl_write(a, d, 4'hF, 12'h0, r, b);
  endtask

  task automatic wait_neg(input string nm, ref logic sig);
    int n = 0;
    while (n < 50) begin @(negedge clock); if (sig) break; n++; end
    if (n >= 50) check(nm, 1, 0);
  endtask

  // Mem-side read reply: accepts the AR then returns one R beat.
  task automatic serve_read(input logic [63:0] d, input logic [1:0] rs, input logic [33:0] exp_addr);
    wait_neg("mem_ar_timeout", mem_0_ar_valid);
    check("mem_ar_addr", {mem_0_ar_bits_size, mem_0_ar_bits_len, mem_0_ar_bits_id, mem_0_ar_bits_addr},
          {3'd3, 8'd0, 16'd0, exp_addr});
    @(posedge clock); #1; mem_0_ar_ready = 1;
    @(posedge clock); #1; mem_0_ar_ready = 0;
    mem_0_r_valid = 1; mem_0_r_bits_data = d; mem_0_r_bits_resp = rs; mem_0_r_bits_last = 1;
    wait_neg("mem_r_ready_timeout", mem_0_r_ready);
    @(posedge clock); #1; mem_0_r_valid = 0;
  endtask

  logic [1:0]  resp;
  logic [11:0] bid;

  initial begin
    reset = 0;
    ctrl_ar_valid = 0; ctrl_ar_bits_addr = 0; ctrl_ar_bits_id = 0; ctrl_ar_bits_size = 3'd2; ctrl_ar_bits_len = 0;
    ctrl_aw_valid = 0; ctrl_aw_bits_addr = 0; ctrl_aw_bits_id = 0; ctrl_aw_bits_size = 3'd2; ctrl_aw_bits_len = 0;
    ctrl_w_valid = 0; ctrl_w_bits_strb = 0; ctrl_w_bits_data = 0; ctrl_w_bits_last = 1;
    ctrl_r_ready = 0; ctrl_b_ready = 0;
    mem_0_ar_ready = 0; mem_0_aw_ready = 0; mem_0_w_ready = 0;
    mem_0_r_valid = 0; mem_0_r_bits_resp = 0; mem_0_r_bits_id = 0; mem_0_r_bits_data = 0; mem_0_r_bits_last = 0;
    mem_0_b_valid = 0; mem_0_b_bits_resp = 0; mem_0_b_bits_id = 0;
    qsfp_0_channel_up = 1; qsfp_0_tx_ready = 0; qsfp_0_rx_valid = 0; qsfp_0_rx_bits = 0;

    vecs[0]  = mk(1, 12'h004, 32'hA5A5_5A5A, 4'hF, 0, 32'h0, 2'b00);
    vecs[1]  = mk(0, 12'h004, 32'h0, 4'h0, 0, 32'hA5A5_5A5A, 2'b00);
    vecs[2]  = mk(0, 12'h000, 32'h0, 4'h0, 2, 32'h4650_4741, 2'b00);
    vecs[3]  = mk(0, 12'h040, 32'h0, 4'h0, 0, 32'h0, 2'b10);
    vecs[4]  = mk(1, 12'h040, 32'h1, 4'hF, 0, 32'h0, 2'b10);
    vecs[5]  = mk(1, 12'h004, 32'hFFFF_FFFF, 4'h2, 0, 32'h0, 2'b00);
    vecs[6]  = mk(0, 12'h004, 32'h0, 4'h0, 1, 32'hA5A5_FF5A, 2'b00);
    vecs[7]  = mk(0, 12'h020, 32'h0, 4'h0, 0, 32'h0, 2'b00);
    vecs[8]  = mk(1, 12'h000, 32'h1234_5678, 4'hF, 0, 32'h0, 2'b00);
    vecs[9]  = mk(0, 12'h000, 32'h0, 4'h0, 0, 32'h4650_4741, 2'b00);
    vecs[10] = mk(0, 12'h03C, 32'h0, 4'h0, 0, 32'h0, 2'b10);
    vecs[11] = mk(0, 12'h006, 32'h0, 4'h0, 0, 32'hA5A5_FF5A, 2'b00);

    // reset state
    repeat (3) @(negedge clock);
    check("reset_outputs", {ctrl_ar_ready, ctrl_aw_ready, ctrl_w_ready, ctrl_r_valid, ctrl_b_valid,
          mem_0_ar_valid, mem_0_aw_valid, mem_0_w_valid, mem_0_r_ready, mem_0_b_ready,
          qsfp_0_tx_valid, qsfp_0_rx_ready}, 0);
    @(posedge clock); #1 reset = 1;
    repeat (2) @(posedge clock);

    // register-access table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        ctrl_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 12'h100 + 12'(i), resp, bid);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_bid", i), bid, 12'h100 + 12'(i));
      end else begin
        ctrl_read(vecs[i].addr, vecs[i].len, 12'h200 + 12'(i));
        check($sformatf("vec%0d_beats", i), rd_n, vecs[i].len + 1);
        for (int k = 0; k < rd_n; k++) begin
          check($sformatf("vec%0d_data%0d", i, k), rd_data[k], vecs[i].exp_data);
          check($sformatf("vec%0d_last%0d", i, k), rd_last[k], (k == vecs[i].len));
        end
        check($sformatf("vec%0d_rresp", i), rd_resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rid", i), rd_id, 12'h200 + 12'(i));
      end
    end

    // DMA write; AW and W handshake on separate cycles
    qsfp_0_channel_up = 0;
    wr(12'h008, 32'h0000_0040); wr(12'h00C, 32'h1);
    wr(12'h010, 32'h5566_7788); wr(12'h014, 32'h1122_3344);
    wr(12'h020, 32'h2);
    wait_neg("mem_aw_timeout", mem_0_aw_valid);
    check("mem_aw_fields", {mem_0_aw_bits_size, mem_0_aw_bits_len, mem_0_aw_bits_id, mem_0_aw_bits_addr},
          {3'd3, 8'd0, 16'd0, 34'h1_0000_0040});
    check("mem_w_fields", {mem_0_w_valid, mem_0_w_bits_strb, mem_0_w_bits_last}, {1'b1, 8'hFF, 1'b1});
    check("mem_w_data", mem_0_w_bits_data, 64'h1122_3344_5566_7788);
    @(posedge clock); #1 mem_0_aw_ready = 1;
    @(posedge clock); #1 mem_0_aw_ready = 0;
    @(negedge clock);
    check("aw_drop_w_hold", {mem_0_aw_valid, mem_0_w_valid, mem_0_b_ready}, 3'b010);
    @(posedge clock); #1 mem_0_w_ready = 1;
    @(posedge clock); #1 mem_0_w_ready = 0; mem_0_b_valid = 1; mem_0_b_bits_resp = 0;
    wait_neg("mem_b_ready_timeout", mem_0_b_ready);
    @(posedge clock); #1 mem_0_b_valid = 0;
    ctrl_read(12'h024, 0, 0); check("status_after_dma_wr", rd_data[0], 32'h2);
    check("aw_count_1", aw_cnt, 1);

    // DMA read
    wr(12'h020, 32'h1);
    serve_read(64'hDEAD_BEEF_CAFE_F00D, 2'b00, 34'h1_0000_0040);
    ctrl_read(12'h018, 0, 0); check("rdata_lo", rd_data[0], 32'hCAFE_F00D);
    ctrl_read(12'h01C, 0, 0); check("rdata_hi", rd_data[0], 32'hDEAD_BEEF);
    ctrl_read(12'h024, 0, 0); check("status_after_dma_rd", rd_data[0], 32'h2);

    // rejected commands
    wr(12'h020, 32'h3);
    ctrl_read(12'h024, 0, 0); check("status_cmd3", rd_data[0], 32'h10);
    wr(12'h020, 32'h1);
    wr(12'h020, 32'h2);
    ctrl_read(12'h024, 0, 0); check("status_cmd_busy", rd_data[0], 32'h11);
    serve_read(64'h0, 2'b10, 34'h1_0000_0040);
    ctrl_read(12'h024, 0, 0); check("status_slverr_latched", rd_data[0], 32'h1A);
    check("traffic_counts", {aw_cnt[7:0], ar_cnt[7:0]}, {8'd1, 8'd2});

    // RX mailbox
    qsfp_0_channel_up = 1;
    @(posedge clock); #1 qsfp_0_rx_valid = 1; qsfp_0_rx_bits = 64'hAAAA;
    @(negedge clock); check("rx_ready_empty", qsfp_0_rx_ready, 1);
    @(posedge clock); #1 qsfp_0_rx_bits = 64'h55;
    repeat (3) @(negedge clock);
    check("rx_ready_full", qsfp_0_rx_ready, 0);
    ctrl_read(12'h034, 0, 0); check("rx_first_word", rd_data[0], 32'hAAAA);
    ctrl_read(12'h024, 0, 0); check("status_rx_full", rd_data[0] & 32'h700, 32'h600);
    wr(12'h030, 32'h2);
    @(posedge clock); #1 qsfp_0_rx_valid = 0;
    ctrl_read(12'h034, 0, 0); check("rx_after_pop", rd_data[0], 32'h55);
    wr(12'h030, 32'h2);
    qsfp_0_channel_up = 0;
    @(negedge clock); check("rx_ready_chan_down", qsfp_0_rx_ready, 0);

    // TX mailbox, stalled by tx_ready
    qsfp_0_channel_up = 1;
    wr(12'h028, 32'h89AB_CDEF); wr(12'h02C, 32'h0123_4567); wr(12'h030, 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("tx_hold%0d", c), {qsfp_0_tx_valid, qsfp_0_tx_bits}, {1'b1, 64'h0123_4567_89AB_CDEF});
    end
    ctrl_read(12'h024, 0, 0); check("status_tx_busy", rd_data[0] & 32'h700, 32'h500);
    @(posedge clock); #1 qsfp_0_tx_ready = 1;
    @(posedge clock); #1 qsfp_0_tx_ready = 0;
    @(negedge clock); check("tx_done", qsfp_0_tx_valid, 0);
    ctrl_read(12'h024, 0, 0); check("status_tx_idle", rd_data[0] & 32'h700, 32'h400);

    // TX with link down: word held, valid masked
    wr(12'h028, 32'h1111_2222);
    qsfp_0_channel_up = 0;
    wr(12'h030, 32'h1);
    @(negedge clock); check("tx_masked", {qsfp_0_tx_valid, qsfp_0_rx_ready}, 2'b00);
    ctrl_read(12'h024, 0, 0); check("status_tx_pending", rd_data[0] & 32'h700, 32'h100);
    qsfp_0_channel_up = 1;
    @(negedge clock);
    check("tx_resume", {qsfp_0_tx_valid, qsfp_0_tx_bits}, {1'b1, 64'h0123_4567_1111_2222});
    @(posedge clock); #1 qsfp_0_tx_ready = 1;
    @(posedge clock); #1 qsfp_0_tx_ready = 0;

    // reset mid-transaction
    wr(12'h020, 32'h1);
    @(negedge clock); check("ar_pending", mem_0_ar_valid, 1);
    #2 reset = 0;
    #1 check("reset_abort", {mem_0_ar_valid, ctrl_ar_ready, ctrl_aw_ready, ctrl_w_ready, qsfp_0_rx_ready}, 0);
    @(posedge clock); #1 reset = 1;
    repeat (2) @(posedge clock);
    ctrl_read(12'h004, 0, 0); check("scratch_after_reset", rd_data[0], 32'h0);
    ctrl_read(12'h024, 0, 0); check("status_after_reset", rd_data[0], 32'h400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
